// File: rtl/test_status_pkg.sv
// -----------------------------------------------------------------------------
// test_status_pkg
//   Shared types and helpers for the test status collector.
//   - status_t   : verdict encoding exposed on the collector's status port.
//   - idx_width  : width needed to hold an index into an n-entry vector,
//                  never less than 1 so a single-test build still has a port.
// -----------------------------------------------------------------------------
package test_status_pkg;

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_PASS    = 2'b01,
    ST_FAIL    = 2'b10,
    ST_TIMEOUT = 2'b11
  } status_t;

  // Smallest w >= 1 with 2**w >= n. Written as a loop so it stays a plain
  // constant function usable in parameter declarations.
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) begin
      w = w + 1;
    end
    return w;
  endfunction

endpackage : test_status_pkg

// File: rtl/lowest_set_idx.sv
// -----------------------------------------------------------------------------
// lowest_set_idx
//   Purely combinational priority encoder: reports the index of the lowest set
//   bit of vec_i and whether any bit is set at all.
// Ports
//   vec_i  in   N   input vector
//   idx_o  out  W   index of the lowest set bit (0 when vec_i is all zero)
//   vld_o  out  1   at least one bit of vec_i is set
// -----------------------------------------------------------------------------
module lowest_set_idx #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic [N-1:0] vec_i,
  output logic [W-1:0] idx_o,
  output logic         vld_o
);

  // Scan from the top down so the last match written is the lowest index.
  always_comb begin
    idx_o = '0;
    vld_o = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (vec_i[i]) begin
        idx_o = W'(i);
        vld_o = 1'b1;
      end
    end
  end

endmodule : lowest_set_idx

// File: rtl/test_status_collector.sv
// -----------------------------------------------------------------------------
// test_status_collector
//   Watches the fail/finish strobes of NUM_TESTS test harness instances and
//   produces a single registered verdict (PASS, FAIL or TIMEOUT). While the
//   verdict is still RUN, fail and finish are OR-ed into sticky masks and the
//   RUN cycles are counted. Once a verdict is reached every register freezes
//   until reset.
// Parameters
//   NUM_TESTS       number of observed tests (>= 1)
//   TIMEOUT_CYCLES  RUN edges before TIMEOUT; 0 disables the watchdog
//   CNT_W           width of the saturating cycle counter
// Ports
//   clock           in   1          all state changes on the rising edge
//   reset           in   1          asynchronous, active-high, clears all state
//   fail            in   NUM_TESTS  per-test fail (pulse or level)
//   finish          in   NUM_TESTS  per-test finish (pulse or level)
//   done            out  1          verdict reached (status != RUN)
//   pass            out  1          status == PASS
//   status          out  2          status_t encoding of the verdict
//   fail_mask       out  NUM_TESTS  sticky OR of fail while RUN
//   finish_mask     out  NUM_TESTS  sticky OR of finish while RUN
//   first_fail_vld  out  1          first_fail_idx holds a captured index
//   first_fail_idx  out  IDX_W      lowest index set on the first failing edge
//   cycle_count     out  CNT_W      rising edges spent in RUN (saturating)
// -----------------------------------------------------------------------------
module test_status_collector
  import test_status_pkg::*;
#(
  parameter  int NUM_TESTS      = 3,
  parameter  int TIMEOUT_CYCLES = 100,
  parameter  int CNT_W          = 32,
  localparam int IDX_W          = idx_width(NUM_TESTS)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_TESTS-1:0] fail,
  input  logic [NUM_TESTS-1:0] finish,
  output logic                 done,
  output logic                 pass,
  output logic [1:0]           status,
  output logic [NUM_TESTS-1:0] fail_mask,
  output logic [NUM_TESTS-1:0] finish_mask,
  output logic                 first_fail_vld,
  output logic [IDX_W-1:0]     first_fail_idx,
  output logic [CNT_W-1:0]     cycle_count
);

  // Timeout threshold expressed in the widened counter domain so the compare
  // against count+1 cannot overflow, even when the counter is all ones.
  localparam logic [CNT_W:0] TIMEOUT_THR = (CNT_W + 1)'(TIMEOUT_CYCLES);

  status_t              state_q, state_d;
  logic [NUM_TESTS-1:0] fail_mask_q, fail_mask_d;
  logic [NUM_TESTS-1:0] finish_mask_q, finish_mask_d;
  logic                 first_fail_vld_q, first_fail_vld_d;
  logic [IDX_W-1:0]     first_fail_idx_q, first_fail_idx_d;
  logic [CNT_W-1:0]     cycle_count_q, cycle_count_d;

  // Priority encoder looks at the raw fail inputs of the current edge, not
  // the mask: the first failing edge is the only one ever captured.
  logic [IDX_W-1:0]     enc_idx;
  logic                 enc_vld;

  lowest_set_idx #(
    .N (NUM_TESTS),
    .W (IDX_W)
  ) u_lowest_set_idx (
    .vec_i (fail),
    .idx_o (enc_idx),
    .vld_o (enc_vld)
  );

  // Unsaturated count+1, one bit wider, used only for the timeout compare.
  logic [CNT_W:0] count_plus1;
  assign count_plus1 = {1'b0, cycle_count_q} + (CNT_W + 1)'(1);

  // Next-state and datapath update. Outside RUN nothing changes, which is
  // what freezes masks, counter and first-fail capture in terminal states.
  always_comb begin
    state_d          = state_q;
    fail_mask_d      = fail_mask_q;
    finish_mask_d    = finish_mask_q;
    first_fail_vld_d = first_fail_vld_q;
    first_fail_idx_d = first_fail_idx_q;
    cycle_count_d    = cycle_count_q;

    if (state_q == ST_RUN) begin
      fail_mask_d   = fail_mask_q | fail;
      finish_mask_d = finish_mask_q | finish;
      cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + 1'b1;

      // Verdict priority: fail beats all-finished beats the watchdog, so a
      // fail coinciding with the final finish or the timeout edge is FAIL.
      if (enc_vld) begin
        state_d = ST_FAIL;
        if (!first_fail_vld_q) begin
          first_fail_vld_d = 1'b1;
          first_fail_idx_d = enc_idx;
        end
      end else if (&finish_mask_d) begin
        state_d = ST_PASS;
      end else if ((TIMEOUT_CYCLES != 0) && (count_plus1 == TIMEOUT_THR)) begin
        state_d = ST_TIMEOUT;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q          <= ST_RUN;
      fail_mask_q      <= '0;
      finish_mask_q    <= '0;
      first_fail_vld_q <= 1'b0;
      first_fail_idx_q <= '0;
      cycle_count_q    <= '0;
    end else begin
      state_q          <= state_d;
      fail_mask_q      <= fail_mask_d;
      finish_mask_q    <= finish_mask_d;
      first_fail_vld_q <= first_fail_vld_d;
      first_fail_idx_q <= first_fail_idx_d;
      cycle_count_q    <= cycle_count_d;
    end
  end

  // All outputs are taken straight from registers: no input reaches an
  // output without passing a clock edge.
  assign status         = state_q;
  assign done           = (state_q != ST_RUN);
  assign pass           = (state_q == ST_PASS);
  assign fail_mask      = fail_mask_q;
  assign finish_mask    = finish_mask_q;
  assign first_fail_vld = first_fail_vld_q;
  assign first_fail_idx = first_fail_idx_q;
  assign cycle_count    = cycle_count_q;

endmodule : test_status_collector

// File: tb/tb_test_status_collector.sv
// -----------------------------------------------------------------------------
// tb_test_status_collector
//   Directed bench for test_status_collector with NUM_TESTS=3. A main instance
//   uses TIMEOUT_CYCLES=100; two side instances (watchdog disabled, and a
//   4-bit counter) share the same inputs and are only checked while all
//   inputs are idle.
// -----------------------------------------------------------------------------
module tb_test_status_collector;

  localparam logic [1:0] S_RUN     = 2'b00;
  localparam logic [1:0] S_PASS    = 2'b01;
  localparam logic [1:0] S_FAIL    = 2'b10;
  localparam logic [1:0] S_TIMEOUT = 2'b11;

  logic        clock;
  logic        reset;
  logic [2:0]  fail;
  logic [2:0]  finish;

  logic        done, pass, ff_vld;
  logic [1:0]  status, ff_idx;
  logic [2:0]  fail_mask, finish_mask;
  logic [31:0] cycle_count;

  logic        nt_done, nt_pass, nt_ff_vld;
  logic [1:0]  nt_status, nt_ff_idx;
  logic [2:0]  nt_fail_mask, nt_finish_mask;
  logic [31:0] nt_cycle_count;

  logic        sat_done, sat_pass, sat_ff_vld;
  logic [1:0]  sat_status, sat_ff_idx;
  logic [2:0]  sat_fail_mask, sat_finish_mask;
  logic [3:0]  sat_cycle_count;

  int n_checks = 0;
  int n_errors = 0;

  test_status_collector #(.NUM_TESTS(3), .TIMEOUT_CYCLES(100), .CNT_W(32)) dut (
    .clock(clock), .reset(reset), .fail(fail), .finish(finish),
    .done(done), .pass(pass), .status(status),
    .fail_mask(fail_mask), .finish_mask(finish_mask),
    .first_fail_vld(ff_vld), .first_fail_idx(ff_idx),
    .cycle_count(cycle_count)
  );

  test_status_collector #(.NUM_TESTS(3), .TIMEOUT_CYCLES(0), .CNT_W(32)) dut_nt (
    .clock(clock), .reset(reset), .fail(fail), .finish(finish),
    .done(nt_done), .pass(nt_pass), .status(nt_status),
    .fail_mask(nt_fail_mask), .finish_mask(nt_finish_mask),
    .first_fail_vld(nt_ff_vld), .first_fail_idx(nt_ff_idx),
    .cycle_count(nt_cycle_count)
  );

  test_status_collector #(.NUM_TESTS(3), .TIMEOUT_CYCLES(0), .CNT_W(4)) dut_sat (
    .clock(clock), .reset(reset), .fail(fail), .finish(finish),
    .done(sat_done), .pass(sat_pass), .status(sat_status),
    .fail_mask(sat_fail_mask), .finish_mask(sat_finish_mask),
    .first_fail_vld(sat_ff_vld), .first_fail_idx(sat_ff_idx),
    .cycle_count(sat_cycle_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of run, expected $finish before 200000");
    $fatal(1, "bench watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One rising edge; outputs are observed 1 time unit after it.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Hold reset across two edges, release 1 unit after an edge; the next
  // rising edge is then edge 1.
  task automatic do_reset();
    reset  = 1'b1;
    fail   = 3'b000;
    finish = 3'b000;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".status"}, 64'(status), 64'(S_RUN));
    check({tag, ".done"}, 64'(done), 64'd0);
    check({tag, ".pass"}, 64'(pass), 64'd0);
    check({tag, ".fail_mask"}, 64'(fail_mask), 64'd0);
    check({tag, ".finish_mask"}, 64'(finish_mask), 64'd0);
    check({tag, ".ff_vld"}, 64'(ff_vld), 64'd0);
    check({tag, ".ff_idx"}, 64'(ff_idx), 64'd0);
    check({tag, ".cycle_count"}, 64'(cycle_count), 64'd0);
  endtask

  // finish[0..2] pulsed at edges 10, 20, 30 -> PASS after edge 30.
  task automatic play_pass(input string tag);
    for (int e = 1; e <= 30; e++) begin
      finish = (e == 10) ? 3'b001 : (e == 20) ? 3'b010 : (e == 30) ? 3'b100 : 3'b000;
      tick();
      if (e == 29) check({tag, ".run_at29"}, 64'(status), 64'(S_RUN));
    end
    finish = 3'b000;
    check({tag, ".status"}, 64'(status), 64'(S_PASS));
    check({tag, ".pass"}, 64'(pass), 64'd1);
    check({tag, ".done"}, 64'(done), 64'd1);
    check({tag, ".finish_mask"}, 64'(finish_mask), 64'b111);
    check({tag, ".cycle_count"}, 64'(cycle_count), 64'd30);
    check({tag, ".fail_mask"}, 64'(fail_mask), 64'd0);
    $display("scenario %s: status=%0d cycle_count=%0d", tag, status, cycle_count);
  endtask

  initial begin
    reset  = 1'b1;
    fail   = 3'bxxx;
    finish = 3'bxxx;
    repeat (2) @(posedge clock);
    #1;
    check_cleared("reset");
    $display("scenario reset: status=%0d", status);

    // 1: clean pass
    do_reset();
    play_pass("s1");

    // 2: fail[1] at edge 12 after finish[0] at edge 5, then inputs ignored
    do_reset();
    for (int e = 1; e <= 12; e++) begin
      finish = (e == 5) ? 3'b001 : 3'b000;
      fail   = (e == 12) ? 3'b010 : 3'b000;
      tick();
    end
    fail = 3'b000;
    check("s2.status", 64'(status), 64'(S_FAIL));
    check("s2.fail_mask", 64'(fail_mask), 64'b010);
    check("s2.ff_idx", 64'(ff_idx), 64'd1);
    check("s2.ff_vld", 64'(ff_vld), 64'd1);
    check("s2.cycle_count", 64'(cycle_count), 64'd12);
    check("s2.pass", 64'(pass), 64'd0);
    check("s2.finish_mask", 64'(finish_mask), 64'b001);
    fail   = 3'b001;
    finish = 3'b111;
    repeat (3) tick();
    fail   = 3'b000;
    finish = 3'b000;
    check("s2.frozen_status", 64'(status), 64'(S_FAIL));
    check("s2.frozen_count", 64'(cycle_count), 64'd12);
    check("s2.frozen_idx", 64'(ff_idx), 64'd1);
    check("s2.frozen_fmask", 64'(finish_mask), 64'b001);
    $display("scenario s2: status=%0d idx=%0d", status, ff_idx);

    // 3a: two fails on the same edge -> lowest index
    do_reset();
    for (int e = 1; e <= 7; e++) begin
      fail = (e == 7) ? 3'b101 : 3'b000;
      tick();
    end
    fail = 3'b000;
    check("s3a.status", 64'(status), 64'(S_FAIL));
    check("s3a.ff_idx", 64'(ff_idx), 64'd0);
    check("s3a.fail_mask", 64'(fail_mask), 64'b101);
    $display("scenario s3a: idx=%0d mask=%b", ff_idx, fail_mask);

    // 3b: fail[2] coincides with the final finish -> FAIL
    do_reset();
    for (int e = 1; e <= 9; e++) begin
      finish = (e == 3) ? 3'b001 : (e == 5) ? 3'b010 : (e == 9) ? 3'b100 : 3'b000;
      fail   = (e == 9) ? 3'b100 : 3'b000;
      tick();
    end
    fail   = 3'b000;
    finish = 3'b000;
    check("s3b.status", 64'(status), 64'(S_FAIL));
    check("s3b.ff_idx", 64'(ff_idx), 64'd2);
    check("s3b.finish_mask", 64'(finish_mask), 64'b111);
    check("s3b.cycle_count", 64'(cycle_count), 64'd9);
    $display("scenario s3b: status=%0d", status);

    // 4: idle run; main times out at 100, others keep counting
    do_reset();
    for (int e = 1; e <= 500; e++) begin
      tick();
      if (e == 99)  check("s4.run_at99", 64'(status), 64'(S_RUN));
      if (e == 100) begin
        check("s4.status", 64'(status), 64'(S_TIMEOUT));
        check("s4.cycle_count", 64'(cycle_count), 64'd100);
        check("s4.done", 64'(done), 64'd1);
        check("s4.pass", 64'(pass), 64'd0);
      end
      if (e == 20) begin
        check("s4.sat_count", 64'(sat_cycle_count), 64'hf);
        check("s4.sat_status", 64'(sat_status), 64'(S_RUN));
      end
    end
    check("s4.nt_status", 64'(nt_status), 64'(S_RUN));
    check("s4.nt_count", 64'(nt_cycle_count), 64'd500);
    check("s4.frozen_count", 64'(cycle_count), 64'd100);
    check("s4.sat_hold", 64'(sat_cycle_count), 64'hf);
    $display("scenario s4: status=%0d nt_status=%0d nt_count=%0d", status, nt_status, nt_cycle_count);

    // 5: async reset between edges 15 and 16, then replay scenario 1
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      finish = (e == 10) ? 3'b001 : 3'b000;
      tick();
    end
    finish = 3'b000;
    check("s5.pre_fmask", 64'(finish_mask), 64'b001);
    check("s5.pre_count", 64'(cycle_count), 64'd15);
    #2;
    reset = 1'b1;
    #1;
    check_cleared("s5.async");
    $display("scenario s5: cleared without clock, status=%0d", status);
    do_reset();
    play_pass("s5.replay");

    // 6: fails after PASS are ignored
    fail = 3'b111;
    repeat (10) tick();
    fail = 3'b000;
    check("s6.status", 64'(status), 64'(S_PASS));
    check("s6.fail_mask", 64'(fail_mask), 64'd0);
    check("s6.cycle_count", 64'(cycle_count), 64'd30);
    check("s6.ff_vld", 64'(ff_vld), 64'd0);
    $display("scenario s6: status=%0d fail_mask=%b", status, fail_mask);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule : tb_test_status_collector
